// File: rtl/dmem_wait_responder.sv
// Data-memory responder with a wait-state ready/valid handshake for the MEM stage.
// Optional macro DMEM_RANDOM_WAIT_EN adds LFSR-driven extra wait cycles.
module dmem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_dmem_addr,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  input  logic [31:0] i_dmem_wdata,
  input  logic [3:0]  i_dmem_mask,
  output logic        o_dmem_ready,
  output logic        o_dmem_valid,
  output logic [31:0] o_dmem_rdata
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  mask;
    logic              wr;
  } req_t;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  logic              accept_c;
  logic [CNT_W-1:0]  cnt_load_c;
  logic              addr_unused_c;

  // Byte offset and bits above the word index alias away.
  assign addr_unused_c = ^{i_dmem_addr[1:0], i_dmem_addr[31:2+IDX_W]};

  assign accept_c = (state_q == S_IDLE) && (i_dmem_ren || i_dmem_wen);

`ifdef DMEM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [4:0]  wait_sum_c;

  // Fibonacci LFSR (taps 16,14,13,11), stepped once per accepted request.
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept_c) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    wait_sum_c = 5'(LATENCY) + 5'(lfsr_q[1:0]);
    cnt_load_c = (wait_sum_c > 5'd15) ? 4'hF : wait_sum_c[3:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign cnt_load_c = CNT_W'(LATENCY);
`endif

  // Next-state, capture and response logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          req_d.idx   = i_dmem_addr[2 +: IDX_W];
          req_d.wdata = i_dmem_wdata;
          req_d.mask  = i_dmem_mask;
          req_d.wr    = i_dmem_wen;
          cnt_d       = cnt_load_c;
          state_d     = (cnt_load_c == '0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = 1'b1;
        rdata_d = req_q.wr ? '0 : mem_q[req_q.idx];
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; a write lands only on the RESP edge.
  always_ff @(posedge i_clk) begin
    if (state_q == S_RESP && req_q.wr) begin
      for (int b = 0; b < int'(LANES); b++) begin
        if (req_q.mask[b]) begin
          mem_q[req_q.idx][8*b +: 8] <= req_q.wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_dmem_ready = ready_q;
  assign o_dmem_valid = valid_q;
  assign o_dmem_rdata = rdata_q;

endmodule
